// File: rtl/axi_arb_pkg.sv
// Shared types and helpers for the AXI4 read/write round-robin arbiters.
// Exports: wr_state_t, N_MASTER_DEF, RR_MAXN, rr_next().
package axi_arb_pkg;

  localparam int N_MASTER_DEF = 4;
  localparam int RR_MAXN      = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    RESP = 2'd2
  } wr_state_t;

  // One-hot pick of the first set bit of req, searching
  // ptr+1, ptr+2, ... ptr+n modulo n. Zero when req is empty.
  // Descending k so the nearest requester is written last.
  function automatic logic [RR_MAXN-1:0] rr_next(
    input logic [RR_MAXN-1:0] req,
    input logic [2:0]         ptr,
    input int                 n
  );
    logic [RR_MAXN-1:0] gnt;
    logic [2:0]         sel;
    gnt = '0;
    for (int k = RR_MAXN; k >= 1; k--) begin
      if (k <= n) begin
        sel = 3'((int'(ptr) + k) % n);
        if (req[sel]) begin
          gnt      = '0;
          gnt[sel] = 1'b1;
        end
      end
    end
    return gnt;
  endfunction

endpackage

// File: rtl/axi_rr_pick.sv
// Combinational round-robin picker shared by the read/write arbiters.
// Ports: i_req, i_ptr in; o_gnt (one-hot), o_id, o_any out.
module axi_rr_pick
  import axi_arb_pkg::*;
#(
  parameter  int N  = N_MASTER_DEF,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_id,
  output logic          o_any
);

  logic [RR_MAXN-1:0] w_req8;
  logic [2:0]         w_ptr3;
  logic [RR_MAXN-1:0] w_gnt8;

  always_comb begin
    w_req8         = '0;
    w_req8[N-1:0]  = i_req;
    w_ptr3         = '0;
    w_ptr3[IW-1:0] = i_ptr;
    w_gnt8         = rr_next(w_req8, w_ptr3, N);
  end

  assign o_gnt = w_gnt8[N-1:0];
  assign o_any = |i_req;

  always_comb begin
    o_id = '0;
    for (int i = 0; i < RR_MAXN; i++) begin
      if (w_gnt8[i]) o_id = IW'(i);
    end
  end

endmodule

// File: rtl/axi_wr_rr_arbiter.sv
// Round-robin AXI4 write-channel arbiter: one owner holds AW/W/B
// from grant through the B handshake; optional watchdog release.
// Ports: ACLK, ARESETn; per-master AWVALID, WVALID, WLAST, BREADY;
// muxed m_AWREADY, m_WREADY, m_BVALID; out wgrnt, wgrnt_id, busy,
// wto_err (pulse), wto_id.
module axi_wr_rr_arbiter
  import axi_arb_pkg::*;
#(
  parameter  int N_MASTER = N_MASTER_DEF,
  parameter  int TIMEOUT  = 0,
  localparam int IW       = $clog2(N_MASTER)
) (
  input  logic                ACLK,
  input  logic                ARESETn,
  input  logic [N_MASTER-1:0] AWVALID,
  input  logic [N_MASTER-1:0] WVALID,
  input  logic [N_MASTER-1:0] WLAST,
  input  logic [N_MASTER-1:0] BREADY,
  input  logic                m_AWREADY,
  input  logic                m_WREADY,
  input  logic                m_BVALID,
  output logic [N_MASTER-1:0] wgrnt,
  output logic [IW-1:0]       wgrnt_id,
  output logic                busy,
  output logic                wto_err,
  output logic [IW-1:0]       wto_id
);

  wr_state_t r_state;
  logic [IW-1:0] r_ptr;
  logic r_aw_done;
  logic r_wl_done;

  logic [N_MASTER-1:0] w_req;
  logic [N_MASTER-1:0] w_pick_gnt;
  logic [IW-1:0]       w_pick_id;
  logic                w_pick_any;
  logic w_aw_hs;
  logic w_wl_hs;
  logic w_b_hs;
  logic w_xfer_done;
  logic w_chg;
  logic w_to;

  // W-first masters may win arbitration too.
  assign w_req = AWVALID | WVALID;

  axi_rr_pick #(.N(N_MASTER)) u_pick (
    .i_req (w_req),
    .i_ptr (r_ptr),
    .o_gnt (w_pick_gnt),
    .o_id  (w_pick_id),
    .o_any (w_pick_any)
  );

  assign w_aw_hs = AWVALID[wgrnt_id] & m_AWREADY;
  assign w_wl_hs = WVALID[wgrnt_id] & m_WREADY
                 & WLAST[wgrnt_id];
  assign w_b_hs  = m_BVALID & BREADY[wgrnt_id];

  // Same-cycle completion of AW and WLAST counts.
  assign w_xfer_done = (r_aw_done | w_aw_hs)
                     & (r_wl_done | w_wl_hs);

  // Normal progress out of XFER/RESP; wins over the watchdog.
  assign w_chg = ((r_state == XFER) && w_xfer_done)
              || ((r_state == RESP) && w_b_hs);

  generate
    if (TIMEOUT > 0) begin : g_wdog
      localparam int CW = $clog2(TIMEOUT + 1);
      logic [CW-1:0] r_cnt;

      // r_cnt = cycles already spent in the current state.
      always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
          r_cnt <= '0;
        end else if (r_state == IDLE || w_chg || w_to) begin
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end

      assign w_to = (r_state != IDLE) && !w_chg
                 && (r_cnt == CW'(TIMEOUT - 1));
    end else begin : g_nowdog
      assign w_to = 1'b0;
    end
  endgenerate

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state   <= IDLE;
      r_ptr     <= IW'(N_MASTER - 1);
      r_aw_done <= 1'b0;
      r_wl_done <= 1'b0;
      wgrnt     <= '0;
      wgrnt_id  <= '0;
      busy      <= 1'b0;
      wto_err   <= 1'b0;
      wto_id    <= '0;
    end else begin
      wto_err <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_pick_any) begin
            wgrnt     <= w_pick_gnt;
            wgrnt_id  <= w_pick_id;
            r_ptr     <= w_pick_id;
            busy      <= 1'b1;
            r_aw_done <= 1'b0;
            r_wl_done <= 1'b0;
            r_state   <= XFER;
          end
        end
        XFER: begin
          if (w_to) begin
            wgrnt   <= '0;
            busy    <= 1'b0;
            wto_err <= 1'b1;
            wto_id  <= wgrnt_id;
            r_state <= IDLE;
          end else if (w_chg) begin
            r_state <= RESP;
          end else begin
            r_aw_done <= r_aw_done | w_aw_hs;
            r_wl_done <= r_wl_done | w_wl_hs;
          end
        end
        RESP: begin
          if (w_to) begin
            wgrnt   <= '0;
            busy    <= 1'b0;
            wto_err <= 1'b1;
            wto_id  <= wgrnt_id;
            r_state <= IDLE;
          end else if (w_chg) begin
            wgrnt   <= '0;
            busy    <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: begin
          wgrnt   <= '0;
          busy    <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
